// File: rtl/fir_sample_serializer.sv
// fir_sample_serializer
//   Output-side transmitter for the FIR datapath. Filtered samples arrive via
//   a valid/ready handshake and are buffered in a small FIFO. Each sample is
//   shifted out MSB-first on a three-wire link (sclk, sdo, frame_n).
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_data     sample to transmit
//   in_valid    in_data is valid
//   in_ready    FIFO has room (registered level < FIFO_DEPTH)
//   sclk        serial clock, idles low, receiver samples on rising edge
//   sdo         serial data, MSB first, 0 outside a frame
//   frame_n     low for the duration of one word
//   busy        FSM not in IDLE
//   fifo_level  number of buffered words
module fir_sample_serializer #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          sclk,
  output logic                          sdo,
  output logic                          frame_n,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

  // FIFO storage and pointers
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              push, pop, empty;

  // Serializer state
  state_e            state_q, state_d;
  logic [CW-1:0]     div_q, div_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              sclk_q, sclk_d;
  logic              frame_n_q, frame_n_d;
  logic              start;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // in_ready looks only at the registered level, never at a same-cycle pop.
  assign in_ready = (level_q < LW'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  assign push     = in_valid && in_ready;

  assign wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
  assign rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Next-state logic. The shift register is cleared when a frame ends so
  // sdo (its MSB) reads 0 whenever no frame is active.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    sclk_d    = sclk_q;
    frame_n_d = frame_n_q;
    start     = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: start = !empty;
      SHIFT: begin
        if (div_q == CW'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_cnt_q == '0) begin
            state_d   = GAP;
            sclk_d    = 1'b0;
            frame_n_d = 1'b1;
            shreg_d   = '0;
          end else begin
            // sdo only moves on the falling sclk edge
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q - BW'(1);
            shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
          end
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      GAP: begin
        if (div_q == CW'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!empty) start = 1'b1;
          else        state_d = IDLE;
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Frame launch is shared by IDLE and end-of-GAP.
    if (start) begin
      pop       = 1'b1;
      state_d   = SHIFT;
      div_d     = '0;
      bit_cnt_d = BW'(DATA_W - 1);
      shreg_d   = mem_q[rd_ptr_q];
      sclk_d    = 1'b0;
      frame_n_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      state_q   <= IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      sclk_q    <= 1'b0;
      frame_n_q <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      sclk_q    <= sclk_d;
      frame_n_q <= frame_n_d;
    end
  end

  assign sclk       = sclk_q;
  assign sdo        = shreg_q[DATA_W-1];
  assign frame_n    = frame_n_q;
  assign busy       = (state_q != IDLE);
  assign fifo_level = level_q;

endmodule

// File: tb/tb_fir_sample_serializer.sv
// Bench for fir_sample_serializer: instance A runs CLK_DIV=2, instance B
// runs CLK_DIV=1. A serial receiver on instance A collects finished frames.
module tb_fir_sample_serializer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data_a = '0, in_data_b = '0;
  logic       in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic       in_ready_a, sclk_a, sdo_a, frame_n_a, busy_a;
  logic       in_ready_b, sclk_b, sdo_b, frame_n_b, busy_b;
  logic [2:0] level_a, level_b;

  fir_sample_serializer #(.DATA_W(8), .CLK_DIV(2), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .sclk(sclk_a), .sdo(sdo_a), .frame_n(frame_n_a),
    .busy(busy_a), .fifo_level(level_a));

  fir_sample_serializer #(.DATA_W(8), .CLK_DIV(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .sclk(sclk_b), .sdo(sdo_b), .frame_n(frame_n_b),
    .busy(busy_b), .fifo_level(level_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial receiver on instance A
  logic       mon_prev_fn = 1'b1, mon_prev_sclk = 1'b0, mon_in = 1'b0;
  logic [7:0] mon_sr = '0;
  int         mon_st = 0;
  int         nstarts = 0;
  logic [7:0] q_word[$];
  int         q_start[$];

  always @(negedge clk) begin
    mon_prev_fn   <= frame_n_a;
    mon_prev_sclk <= sclk_a;
    if (!rst_n) begin
      mon_in <= 1'b0;
    end else if (mon_prev_fn && !frame_n_a) begin
      mon_in  <= 1'b1;
      mon_sr  <= '0;
      mon_st  <= cyc;
      nstarts <= nstarts + 1;
    end else if (mon_in && !mon_prev_fn && frame_n_a) begin
      q_word.push_back(mon_sr);
      q_start.push_back(mon_st);
      mon_in <= 1'b0;
    end else if (mon_in && !mon_prev_sclk && sclk_a) begin
      mon_sr <= {mon_sr[6:0], sdo_a};
    end
  end

  typedef struct {
    int         e;
    logic       vld;
    logic [7:0] din;
    logic       sclk;
    logic       sdo;
    logic       frame_n;
    logic       busy;
    logic [2:0] lvl;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  int nvec = 0, nfail = 0;
  int rel = 0, base = 0, at = 0, ns0 = 0;

  function automatic vec_t mkv(input int e, input logic vld, input logic [7:0] din,
                               input logic s, input logic d, input logic f,
                               input logic b, input logic [2:0] l);
    vec_t v;
    v.e = e; v.vld = vld; v.din = din; v.sclk = s; v.sdo = d;
    v.frame_n = f; v.busy = b; v.lvl = l;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input int dut, input string nm, input vec_t v);
    logic s, d, f, b;
    logic [2:0] l;
    if (dut == 0) begin s = sclk_a; d = sdo_a; f = frame_n_a; b = busy_a; l = level_a; end
    else          begin s = sclk_b; d = sdo_b; f = frame_n_b; b = busy_b; l = level_b; end
    chk({nm, ".sclk"},    32'(s), 32'(v.sclk));
    chk({nm, ".sdo"},     32'(d), 32'(v.sdo));
    chk({nm, ".frame_n"}, 32'(f), 32'(v.frame_n));
    chk({nm, ".busy"},    32'(b), 32'(v.busy));
    chk({nm, ".level"},   32'(l), 32'(v.lvl));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rel++;
  endtask

  task automatic push_a(input logic [7:0] w, output int acc_at);
    logic acc;
    acc = 1'b0;
    in_data_a  = w;
    in_valid_a = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      acc = in_ready_a;
      step();
    end
    in_valid_a = 1'b0;
    acc_at = acc ? rel : -1;
  endtask

  task automatic wait_frames(input int n, input int limit);
    for (int t = 0; t < limit && q_word.size() < n; t++) step();
  endtask

  task automatic wait_idle_a();
    for (int t = 0; t < 200 && busy_a; t++) step();
    chk("idle_before_test", 32'(busy_a), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // single word 0xA5, CLK_DIV=2
    tbl_a.push_back(mkv( 0, 1'b1, 8'hA5, 0, 0, 1, 0, 3'd1));
    tbl_a.push_back(mkv( 1, 1'b0, 8'h00, 0, 1, 0, 1, 3'd0));
    tbl_a.push_back(mkv( 2, 1'b0, 8'h00, 0, 1, 0, 1, 3'd0));
    tbl_a.push_back(mkv( 3, 1'b0, 8'h00, 1, 1, 0, 1, 3'd0));
    tbl_a.push_back(mkv( 5, 1'b0, 8'h00, 0, 0, 0, 1, 3'd0));
    tbl_a.push_back(mkv( 7, 1'b0, 8'h00, 1, 0, 0, 1, 3'd0));
    tbl_a.push_back(mkv( 9, 1'b0, 8'h00, 0, 1, 0, 1, 3'd0));
    tbl_a.push_back(mkv(13, 1'b0, 8'h00, 0, 0, 0, 1, 3'd0));
    tbl_a.push_back(mkv(17, 1'b0, 8'h00, 0, 0, 0, 1, 3'd0));
    tbl_a.push_back(mkv(21, 1'b0, 8'h00, 0, 1, 0, 1, 3'd0));
    tbl_a.push_back(mkv(25, 1'b0, 8'h00, 0, 0, 0, 1, 3'd0));
    tbl_a.push_back(mkv(29, 1'b0, 8'h00, 0, 1, 0, 1, 3'd0));
    tbl_a.push_back(mkv(31, 1'b0, 8'h00, 1, 1, 0, 1, 3'd0));
    tbl_a.push_back(mkv(32, 1'b0, 8'h00, 1, 1, 0, 1, 3'd0));
    tbl_a.push_back(mkv(33, 1'b0, 8'h00, 0, 0, 1, 1, 3'd0));
    tbl_a.push_back(mkv(34, 1'b0, 8'h00, 0, 0, 1, 1, 3'd0));
    tbl_a.push_back(mkv(35, 1'b0, 8'h00, 0, 0, 1, 0, 3'd0));
    // single word 0x80, CLK_DIV=1
    tbl_b.push_back(mkv( 0, 1'b1, 8'h80, 0, 0, 1, 0, 3'd1));
    tbl_b.push_back(mkv( 1, 1'b0, 8'h00, 0, 1, 0, 1, 3'd0));
    tbl_b.push_back(mkv( 2, 1'b0, 8'h00, 1, 1, 0, 1, 3'd0));
    tbl_b.push_back(mkv( 3, 1'b0, 8'h00, 0, 0, 0, 1, 3'd0));
    tbl_b.push_back(mkv( 4, 1'b0, 8'h00, 1, 0, 0, 1, 3'd0));
    tbl_b.push_back(mkv(15, 1'b0, 8'h00, 0, 0, 0, 1, 3'd0));
    tbl_b.push_back(mkv(16, 1'b0, 8'h00, 1, 0, 0, 1, 3'd0));
    tbl_b.push_back(mkv(17, 1'b0, 8'h00, 0, 0, 1, 1, 3'd0));
    tbl_b.push_back(mkv(18, 1'b0, 8'h00, 0, 0, 1, 0, 3'd0));

    // Reset held with in_valid high: nothing is pushed
    in_valid_a = 1'b1;
    in_data_a  = 8'h33;
    repeat (3) step();
    check_outs(0, "reset_hold", mkv(0, 1'b0, 8'h00, 0, 0, 1, 0, 3'd0));
    chk("reset_hold.in_ready", 32'(in_ready_a), 32'(1));
    in_valid_a = 1'b0;
    #2 rst_n = 1'b1;
    step();
    chk("reset_rel.level",    32'(level_a),    32'(0));
    chk("reset_rel.in_ready", 32'(in_ready_a), 32'(1));
    chk("reset_rel.busy",     32'(busy_a),     32'(0));

    // Single word on instance A
    q_word.delete(); q_start.delete();
    rel = -1;
    foreach (tbl_a[i]) begin
      while (rel < tbl_a[i].e - 1) begin in_valid_a = 1'b0; step(); end
      in_valid_a = tbl_a[i].vld;
      in_data_a  = tbl_a[i].din;
      step();
      if (rel == 0) base = cyc;
      check_outs(0, $sformatf("single_e%0d", tbl_a[i].e), tbl_a[i]);
    end
    in_valid_a = 1'b0;
    chk("single.frames", 32'(q_word.size()), 32'(1));
    if (q_word.size() > 0) begin
      chk("single.word",  32'(q_word[0]), 32'h A5);
      chk("single.start", 32'(q_start[0] - base), 32'(1));
    end

    // Burst 0x01..0x06 with back-pressure
    q_word.delete(); q_start.delete();
    push_a(8'h01, at);
    rel = 0;
    base = cyc;
    for (int w = 2; w <= 6; w++) begin
      push_a(8'(w), at);
      chk($sformatf("burst.accept_w%0d", w), 32'(at), 32'((w <= 5) ? (w - 1) : 36));
      if (w == 5) begin
        chk("burst.level_full", 32'(level_a),    32'(4));
        chk("burst.ready_low",  32'(in_ready_a), 32'(0));
      end
    end
    wait_frames(6, 400);
    chk("burst.frames", 32'(q_word.size()), 32'(6));
    for (int i = 0; i < q_word.size(); i++) begin
      chk($sformatf("burst.word%0d", i),  32'(q_word[i]), 32'(i + 1));
      chk($sformatf("burst.start%0d", i), 32'(q_start[i] - base), 32'(1 + 34 * i));
    end
    wait_idle_a();

    // Simultaneous push and pop at level 2
    q_word.delete(); q_start.delete();
    push_a(8'h11, at);
    rel = 0;
    base = cyc;
    push_a(8'h22, at);
    push_a(8'h33, at);
    chk("simul.pre_level", 32'(level_a), 32'(2));
    while (rel < 34) step();
    push_a(8'h44, at);
    chk("simul.accept", 32'(at), 32'(35));
    chk("simul.level",  32'(level_a), 32'(2));
    wait_frames(4, 300);
    chk("simul.frames", 32'(q_word.size()), 32'(4));
    for (int i = 0; i < q_word.size(); i++) begin
      chk($sformatf("simul.word%0d", i),  32'(q_word[i]), 32'(8'h11 * (i + 1)));
      chk($sformatf("simul.start%0d", i), 32'(q_start[i] - base), 32'(1 + 34 * i));
    end
    wait_idle_a();

    // CLK_DIV=1 on instance B
    rel = -1;
    foreach (tbl_b[i]) begin
      while (rel < tbl_b[i].e - 1) begin in_valid_b = 1'b0; step(); end
      in_valid_b = tbl_b[i].vld;
      in_data_b  = tbl_b[i].din;
      step();
      check_outs(1, $sformatf("div1_e%0d", tbl_b[i].e), tbl_b[i]);
    end
    in_valid_b = 1'b0;

    // Reset in the middle of 0xFF with two words queued
    q_word.delete(); q_start.delete();
    push_a(8'hFF, at);
    rel = 0;
    push_a(8'h12, at);
    push_a(8'h34, at);
    chk("abort.pre_level", 32'(level_a), 32'(2));
    while (rel < 14) step();
    chk("abort.pre_sdo",   32'(sdo_a),     32'(1));
    chk("abort.pre_frame", 32'(frame_n_a), 32'(0));
    #2 rst_n = 1'b0;
    #1;
    check_outs(0, "abort_async", mkv(0, 1'b0, 8'h00, 0, 0, 1, 0, 3'd0));
    chk("abort_async.in_ready", 32'(in_ready_a), 32'(1));
    step();
    step();
    rst_n = 1'b1;
    ns0 = nstarts;
    repeat (40) step();
    chk("abort.no_restart", 32'(nstarts), 32'(ns0));
    check_outs(0, "abort_after", mkv(0, 1'b0, 8'h00, 0, 0, 1, 0, 3'd0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
